// File: rtl/adc_capture_pkg.sv
// Shared types and widths for the ADC snapshot capture buffer.
//   SAMPLE_W : width of one ADC sample (offset-binary)
//   PAIR_W   : width of one stored {n, p} sample pair
//   state_t  : capture FSM states
//   pair_t   : stored pair layout, n sample in the upper byte
package adc_capture_pkg;

   localparam int unsigned SAMPLE_W = 8;
   localparam int unsigned PAIR_W   = 16;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      WAIT_TRIG,
      POST,
      DONE
   } state_t;

   typedef struct packed {
      logic [SAMPLE_W-1:0] n;
      logic [SAMPLE_W-1:0] p;
   } pair_t;

endpackage

// File: rtl/adc_capture_buf_if.sv
// Control, sample and readback bundle for adc_capture_buf.
//   master : host/source side (drives samples, control, rd_addr)
//   slave  : capture buffer side (drives busy, done, trig_half, rd_data)
interface adc_capture_buf_if #(
   parameter int unsigned DEPTH = 1024
);
   import adc_capture_pkg::*;

   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic [SAMPLE_W-1:0] adc_data_p;
   logic [SAMPLE_W-1:0] adc_data_n;
   logic                arm;
   logic                abort;
   logic                force_trig;
   logic [SAMPLE_W-1:0] trig_level;
   logic                busy;
   logic                done;
   logic                trig_half;
   logic [ADDR_W-1:0]   rd_addr;
   logic [PAIR_W-1:0]   rd_data;

   modport master (
      output adc_data_p, adc_data_n, arm, abort, force_trig, trig_level, rd_addr,
      input  busy, done, trig_half, rd_data
   );

   modport slave (
      input  adc_data_p, adc_data_n, arm, abort, force_trig, trig_level, rd_addr,
      output busy, done, trig_half, rd_data
   );

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write and one registered read per cycle.
//   clk, rst          : clock, async active-low reset (read register only)
//   we, wr_addr, wr_data : write port
//   rd_addr, rd_data  : read port, 1-cycle latency
module capture_ram
   import adc_capture_pkg::*;
#(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PAIR_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PAIR_W-1:0] rd_data
);

   logic [PAIR_W-1:0] mem [DEPTH];

   // Array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_data <= '0;
      else      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/adc_capture_buf.sv
// Triggered snapshot buffer for a DDR ADC capture path. Records PRE_TRIG
// pairs before a level-crossing (or forced) trigger pair and the remainder
// of a DEPTH-pair window after it, then freezes for readback.
//   clk, rst : capture clock, async active-low reset
//   bus      : samples, arm/abort/force_trig, trig_level, status, read port
module adc_capture_buf
   import adc_capture_pkg::*;
#(
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned PRE_TRIG = 256
) (
   input  logic             clk,
   input  logic             rst,
   adc_capture_buf_if.slave bus
);

   localparam int unsigned ADDR_W     = $clog2(DEPTH);
   localparam int unsigned POST_PAIRS = DEPTH - PRE_TRIG;
   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_PAIRS - 1);
   localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

   state_t              state, state_nxt;
   logic [SAMPLE_W-1:0] sp, sn, sn_prev;
   logic [ADDR_W-1:0]   wr_ptr, pre_cnt, post_cnt, trig_addr;
   logic                busy, done, trig_half;

   logic                xp_c, xn_c, hit_c, wr_en_c, start_c, trig_c;
   logic [ADDR_W-1:0]   phys_c;
   pair_t               wr_pair_c;

   // Crossing detect on the pair currently being written.
   assign xp_c    = (sn_prev < bus.trig_level) && (sp >= bus.trig_level);
   assign xn_c    = (sp < bus.trig_level) && (sn >= bus.trig_level);
   assign hit_c   = xp_c | xn_c | bus.force_trig;
   assign wr_en_c = (state == ARMED) || (state == WAIT_TRIG) || (state == POST);
   assign start_c = bus.arm && !bus.abort && ((state == IDLE) || (state == DONE));
   assign trig_c  = (state == WAIT_TRIG) && hit_c && !bus.abort;

   // Oldest pair of the window sits PRE_TRIG slots behind the trigger pair.
   assign phys_c    = trig_addr - PRE_OFS + bus.rd_addr;
   assign wr_pair_c = '{n: sn, p: sp};

   // Next-state logic; abort overrides everything.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (bus.arm) state_nxt = ARMED;
         ARMED:     if (pre_cnt == PRE_LAST) state_nxt = WAIT_TRIG;
         // A one-pair post window is complete with the trigger write itself.
         WAIT_TRIG: if (hit_c) state_nxt = (POST_PAIRS == 1) ? DONE : POST;
         POST:      if (post_cnt == POST_LAST) state_nxt = DONE;
         DONE:      if (bus.arm) state_nxt = ARMED;
         default:   state_nxt = IDLE;
      endcase
      if (bus.abort) state_nxt = IDLE;
   end

   // State register and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == ARMED) || (state_nxt == WAIT_TRIG) || (state_nxt == POST);
         done  <= (state_nxt == DONE);
      end
   end

   // Input stage, write pointer, counters and trigger latch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp        <= '0;
         sn        <= '0;
         sn_prev   <= '0;
         wr_ptr    <= '0;
         pre_cnt   <= '0;
         post_cnt  <= '0;
         trig_addr <= '0;
         trig_half <= 1'b0;
      end else begin
         sp      <= bus.adc_data_p;
         sn      <= bus.adc_data_n;
         sn_prev <= sn;

         if (start_c)      wr_ptr <= '0;
         else if (wr_en_c) wr_ptr <= wr_ptr + ADDR_W'(1);

         if (start_c)               pre_cnt <= '0;
         else if (state == ARMED)   pre_cnt <= pre_cnt + ADDR_W'(1);

         // The trigger pair is post pair 0, so POST starts counting at 1.
         if (trig_c) begin
            trig_addr <= wr_ptr;
            trig_half <= !xp_c && xn_c;
            post_cnt  <= ADDR_W'(1);
         end else if (state == POST) begin
            post_cnt  <= post_cnt + ADDR_W'(1);
         end
      end
   end

   capture_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_en_c),
      .wr_addr (wr_ptr),
      .wr_data (wr_pair_c),
      .rd_addr (phys_c),
      .rd_data (bus.rd_data)
   );

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.trig_half = trig_half;

endmodule

// File: tb/tb_adc_capture_buf.sv
// Directed bench for adc_capture_buf: two instances (PRE_TRIG 16 and 63,
// DEPTH 64) share sample/control stimulus but have separate arm inputs.
module tb_adc_capture_buf;
   import adc_capture_pkg::*;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned PRE_A = 16;
   localparam int unsigned PRE_B = 63;
   localparam int          N     = 512;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] adc_p = '0, adc_n = '0, lvl = '0;
   logic       frc = 1'b0, abort_s = 1'b0, arm_a = 1'b0, arm_b = 1'b0;
   logic [5:0] rd_addr = '0;

   logic [7:0]  p_of [N];
   logic [7:0]  n_of [N];
   bit          frc_of [N];
   logic [15:0] exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   adc_capture_buf_if #(.DEPTH(DEPTH)) bus_a ();
   adc_capture_buf_if #(.DEPTH(DEPTH)) bus_b ();

   assign bus_a.adc_data_p = adc_p;   assign bus_b.adc_data_p = adc_p;
   assign bus_a.adc_data_n = adc_n;   assign bus_b.adc_data_n = adc_n;
   assign bus_a.force_trig = frc;     assign bus_b.force_trig = frc;
   assign bus_a.trig_level = lvl;     assign bus_b.trig_level = lvl;
   assign bus_a.abort      = abort_s; assign bus_b.abort      = abort_s;
   assign bus_a.rd_addr    = rd_addr; assign bus_b.rd_addr    = rd_addr;
   assign bus_a.arm        = arm_a;   assign bus_b.arm        = arm_b;

   adc_capture_buf #(.DEPTH(DEPTH), .PRE_TRIG(PRE_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   adc_capture_buf #(.DEPTH(DEPTH), .PRE_TRIG(PRE_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   function automatic logic o_busy(input bit b);  return b ? bus_b.busy : bus_a.busy; endfunction
   function automatic logic o_done(input bit b);  return b ? bus_b.done : bus_a.done; endfunction
   function automatic logic o_half(input bit b);  return b ? bus_b.trig_half : bus_a.trig_half; endfunction
   function automatic logic [15:0] o_rd(input bit b); return b ? bus_b.rd_data : bus_a.rd_data; endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Arm at pair 0, stream pairs until done; force_trig follows the pair
   // currently held in the input register (one cycle behind the inputs).
   task automatic capture(input bit b, input int tk, input int n_post, input bit half,
                          input string tag);
      bit seen = 1'b0;
      adc_p = p_of[0]; adc_n = n_of[0]; frc = 1'b0;
      if (b) arm_b = 1'b1; else arm_a = 1'b1;
      step();
      arm_a = 1'b0; arm_b = 1'b0;
      chk({tag, "_busy_rise"}, 32'(o_busy(b)), 32'd1);
      for (int k = 1; k < N && !seen; k++) begin
         adc_p = p_of[k]; adc_n = n_of[k]; frc = frc_of[k-1];
         step();
         if (o_done(b)) begin
            seen = 1'b1;
            chk({tag, "_done_edge"}, 32'(k), 32'(tk + n_post));
            chk({tag, "_busy_fall"}, 32'(o_busy(b)), 32'd0);
         end
      end
      frc = 1'b0;
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_trig_half"}, 32'(o_half(b)), 32'(half));
   endtask

   // Read the whole window with a new address every cycle.
   task automatic read_window(input bit b, input int tk, input int pre, input string tag);
      logic [15:0] e;
      rd_addr = 6'(0);
      exp_q.push_back({n_of[tk - pre], p_of[tk - pre]});
      for (int r = 0; r < int'(DEPTH); r++) begin
         adc_p = 8'($urandom); adc_n = 8'($urandom);
         step();
         e = exp_q.pop_front();
         chk($sformatf("%s_rd%0d", tag, r), 32'(o_rd(b)), 32'(e));
         if (r + 1 < int'(DEPTH)) begin
            rd_addr = 6'(r + 1);
            exp_q.push_back({n_of[tk - pre + r + 1], p_of[tk - pre + r + 1]});
         end
      end
   endtask

   task automatic read_one(input bit b, input int addr, input logic [15:0] exp, input string tag);
      rd_addr = 6'(addr);
      step();
      chk(tag, 32'(o_rd(b)), 32'(exp));
   endtask

   task automatic clear_frc();
      for (int k = 0; k < N; k++) frc_of[k] = 1'b0;
   endtask

   initial begin
      bit done_ever;

      // Reset with random activity on every input, arm included.
      for (int i = 0; i < 6; i++) begin
         adc_p = 8'($urandom); adc_n = 8'($urandom); lvl = 8'($urandom);
         arm_a = 1'($urandom); arm_b = 1'($urandom); frc = 1'($urandom);
         rd_addr = 6'($urandom);
         step();
      end
      chk("rst_busy_a", 32'(bus_a.busy), 32'd0);
      chk("rst_done_a", 32'(bus_a.done), 32'd0);
      chk("rst_rd_a",   32'(bus_a.rd_data), 32'h0000);
      chk("rst_half_a", 32'(bus_a.trig_half), 32'd0);
      chk("rst_busy_b", 32'(bus_b.busy), 32'd0);
      chk("rst_done_b", 32'(bus_b.done), 32'd0);
      arm_a = 1'b0; arm_b = 1'b0; frc = 1'b0;
      rst = 1'b1;
      step();
      chk("post_rst_busy_a", 32'(bus_a.busy), 32'd0);

      // Reset mid-capture forces IDLE without waiting for a clock.
      arm_a = 1'b1; step(); arm_a = 1'b0;
      step(); step();
      chk("mid_busy_before", 32'(bus_a.busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus_a.busy), 32'd0);
      step();
      rst = 1'b1;
      step();

      // Ramp, p-half trigger on pair 64.
      clear_frc();
      for (int k = 0; k < N; k++) begin p_of[k] = 8'(2*k); n_of[k] = 8'(2*k + 1); end
      lvl = 8'h80;
      capture(1'b0, 64, 48, 1'b0, "ramp");
      read_window(1'b0, 64, 16, "ramp");
      read_one(1'b0, 16, 16'h8180, "ramp_trig_pair");

      // n-half trigger on pair 20.
      clear_frc();
      for (int k = 0; k < N; k++) begin
         p_of[k] = (k < 20) ? 8'h00 : 8'h7F;
         n_of[k] = (k < 20) ? 8'h00 : 8'h80;
      end
      capture(1'b0, 20, 48, 1'b1, "nhalf");
      read_window(1'b0, 20, 16, "nhalf");
      read_one(1'b0, 16, 16'h807F, "nhalf_trig_pair");

      // Crossing at pair 5 falls in pre-fill and is ignored; force at pair 30.
      clear_frc();
      for (int k = 0; k < N; k++) begin
         p_of[k] = 8'(k & 63);
         n_of[k] = 8'(64 | (k & 63));
      end
      p_of[5] = 8'h90;
      frc_of[30] = 1'b1;
      capture(1'b0, 30, 48, 1'b0, "mask");
      read_window(1'b0, 30, 16, "mask");

      // Wrap-around on the PRE_TRIG=63 instance, forced trigger at pair 200.
      clear_frc();
      for (int k = 0; k < N; k++) begin p_of[k] = 8'(k); n_of[k] = 8'(3*k + 7); end
      lvl = 8'h00;
      frc_of[200] = 1'b1;
      capture(1'b1, 200, 1, 1'b0, "wrap");
      read_window(1'b1, 200, 63, "wrap");
      read_one(1'b1, 63, {n_of[200], p_of[200]}, "wrap_trig_pair");
      read_one(1'b1, 0, {n_of[137], p_of[137]}, "wrap_oldest");

      // Abort 10 cycles into POST on a ramp that triggers at pair 64.
      clear_frc();
      for (int k = 0; k < N; k++) begin p_of[k] = 8'(2*k); n_of[k] = 8'(2*k + 1); end
      lvl = 8'h80;
      done_ever = 1'b0;
      adc_p = p_of[0]; adc_n = n_of[0]; arm_a = 1'b1;
      step();
      arm_a = 1'b0;
      for (int k = 1; k < 140; k++) begin
         adc_p = p_of[k]; adc_n = n_of[k];
         abort_s = (k == 75);
         step();
         if (k == 74) chk("abort_busy_in_post", 32'(bus_a.busy), 32'd1);
         if (k == 75) chk("abort_busy_fall", 32'(bus_a.busy), 32'd0);
         if (k >= 75 && bus_a.done) done_ever = 1'b1;
      end
      abort_s = 1'b0;
      chk("abort_no_done", 32'(done_ever), 32'd0);

      // arm and abort together: abort wins.
      arm_a = 1'b1; abort_s = 1'b1;
      step();
      arm_a = 1'b0; abort_s = 1'b0;
      step();
      chk("arm_abort_idle", 32'(bus_a.busy), 32'd0);

      // Fresh capture after the abort.
      clear_frc();
      for (int k = 0; k < N; k++) begin
         p_of[k] = (k < 20) ? 8'h00 : 8'h7F;
         n_of[k] = (k < 20) ? 8'h00 : 8'h80;
      end
      capture(1'b0, 20, 48, 1'b1, "rearm");
      read_window(1'b0, 20, 16, "rearm");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_capture_buf.md
# adc_capture_buf

Triggered snapshot buffer for the AD9284 capture path. Sits directly downstream of the IDDR input stage. Consumes the two 8-bit samples delivered per DCO cycle (rising-edge word and falling-edge word). Records a fixed window around a level-crossing or forced trigger into on-chip RAM, then exposes the window through a simple read port for the host/LED debug logic.

## Interface

**Parameters**
- DEPTH, 1024, buffer depth in sample pairs; power of two, ≥ 16.
- PRE_TRIG, 256, pairs kept before the trigger pair; 1 ≤ PRE_TRIG ≤ DEPTH-1.

**Ports**
- clk, in, 1, capture clock (BUFR'd ADC DCO); the only clock.
- rst, in, 1, asynchronous, active-low reset.
- adc_data_p, in, 8, rising-edge (earlier) sample; offset-binary.
- adc_data_n, in, 8, falling-edge (later) sample; offset-binary.
- arm, in, 1, one-cycle pulse: start a capture.
- abort, in, 1, one-cycle pulse: cancel the capture and return to IDLE.
- force_trig, in, 1, level: treat the current pair as the trigger pair.
- trig_level, in, 8, rising-crossing threshold.
- busy, out, 1, high in ARMED, WAIT_TRIG, and POST.
- done, out, 1, high in DONE.
- trig_half, out, 1, 0 = crossing in the p sample, 1 = in the n sample.
- rd_addr, in, log2(DEPTH), logical read index; 0 = oldest pair of the window.
- rd_data, out, 16, {n, p} at rd_addr; registered.

## Operation

- **Input stage.** adc_data_p/n are registered to sp/sn every cycle. sn_prev holds the previous sn.
- **Write side.**
  - In ARMED, WAIT_TRIG, and POST, {sn, sp} is written at wr_ptr every cycle.
  - wr_ptr increments modulo DEPTH (wraps).
- **Crossing detect** on the registered pair:
  - xp = (sn_prev < trig_level) && (sp ≥ trig_level)
  - xn = (sp < trig_level) && (sn ≥ trig_level)
  - Comparisons are unsigned 8-bit.
  - hit = xp | xn | force_trig.
  - trig_half = !xp && xn. force_trig alone gives 0.
- **States**
  - IDLE: no writes. arm → ARMED (wr_ptr = 0, pre_cnt = 0).
  - ARMED: pre_cnt counts written pairs. At pre_cnt == PRE_TRIG-1 → WAIT_TRIG. Hits in ARMED are ignored.
  - WAIT_TRIG: keeps overwriting the circular buffer.
    - On hit: latch trig_addr = wr_ptr and trig_half; post_cnt = 0; → POST.
    - The trigger pair is itself written and counts as post pair 0.
  - POST: at post_cnt == DEPTH-PRE_TRIG-1 (last write) → DONE.
  - DONE: no writes; buffer frozen. arm → ARMED (new capture).
- **Priority**
  - abort in any state → IDLE next cycle. Buffer contents are retained; done clears.
  - abort and arm in the same cycle: abort wins.
  - arm in ARMED, WAIT_TRIG, or POST is ignored.
- **Read side**
  - phys = (trig_addr - PRE_TRIG + rd_addr) mod DEPTH. Computed in log2(DEPTH) bits with natural wrap.
  - rd_data = ram[phys].
  - Valid content only while done = 1. Reads in other states return stale or undefined data but must not disturb capture.
- **Window layout.** rd_addr PRE_TRIG is the trigger pair. rd_addr DEPTH-1 is the last post pair.

## Timing

- **Reset values:** state IDLE; busy 0, done 0, trig_half 0, rd_data 0x0000, wr_ptr 0, trig_addr 0, sn_prev 0x00.
- **Input to RAM latency:** a pair present on adc_data_p/n at edge t is written at edge t+1.
- **Trigger:** the hit is evaluated on the same registered pair that is being written, so the trigger pair is exactly the pair whose crossing fired.
- **busy** rises 1 cycle after arm is sampled.
- **done** rises the cycle after the final POST write. busy falls the same cycle.
- **Read latency:** 1 cycle, rd_addr to rd_data. A new rd_addr every cycle is allowed.
- **Reset mid-capture:** immediate IDLE. RAM contents are undefined.
- **Throughput:** one pair per clk, no stalls. The RAM must sustain 1 write + 1 read per cycle.

## Structure

- **Shared package adc_capture_pkg:**
  - state enum {IDLE, ARMED, WAIT_TRIG, POST, DONE};
  - SAMPLE_W = 8;
  - PAIR_W = 16.
- **Sub-module capture_ram:** simple dual-port, 1 write / 1 registered read, PAIR_W × DEPTH, inferred block RAM.
- **Top-level logic:** FSM, counters, crossing detect, and address arithmetic stay in adc_capture_buf.

## Test plan

All scenarios use DEPTH = 64, PRE_TRIG = 16 unless stated.

- **Reset:** rst low with random inputs → busy = 0, done = 0, rd_data = 0x0000, trig_half = 0. arm ignored while rst is low.
- **Ramp, p-half trigger:** p = 2k, n = 2k+1 (mod 256) per cycle k; trig_level 0x80; arm at k = 0.
  - Trigger on pair 64 (the first pair with sp ≥ 0x80), trig_half = 0.
  - Reading rd_addr 0..63 returns pairs 48..111 in order.
  - rd_addr 16 = {0x81, 0x80}.
- **n-half trigger:** p = 0x7F, n = 0x80 constant after pairs of 0x00.
  - First hit is in the n sample, trig_half = 1.
  - rd_addr 16 = {0x80, 0x7F}.
- **Pre-fill masking:** crossing at pair 5 after arm, none later, then force_trig at pair 30.
  - Trigger is pair 30, not 5.
  - done occurs 48 cycles after the trigger write.
- **Wrap-around:** PRE_TRIG = 63, trigger after 200 pairs.
  - phys address wraps correctly.
  - rd_addr 63 = trigger pair; rd_addr 0 = the pair 63 earlier.
- **Abort and re-arm:** abort 10 cycles into POST → IDLE, done never asserts. arm and abort in the same cycle → stays IDLE. A fresh arm then completes a normal capture.
